// File: rtl/cs_pkg.sv
// Shared constants and types for the CS datapath, its output buffer and the benches.
package cs_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 10;

    // Run cycles CS needs to fill its 9-sample window before Y is meaningful.
    localparam int DEFAULT_WARMUP = 9;

    typedef logic [X_W-1:0] x_t;
    typedef logic [Y_W-1:0] y_t;

endpackage

// File: rtl/cs_y_buffer_if.sv
// Stream-in / valid-ready-out port bundle of the CS Y output buffer.
interface cs_y_buffer_if
    import cs_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OVF_W = 16
);

    logic                     run;
    y_t                       Y;
    y_t                       dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [$clog2(DEPTH):0]   level;
    logic                     full;
    logic                     empty;
    logic [OVF_W-1:0]         ovf_cnt;

    // The buffer is the slave; the CS side plus the consumer form the master.
    modport slave (
        input  run,
        input  Y,
        input  dout_ready,
        output dout,
        output dout_valid,
        output level,
        output full,
        output empty,
        output ovf_cnt
    );

    modport master (
        output run,
        output Y,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  level,
        input  full,
        input  empty,
        input  ovf_cnt
    );

endinterface

// File: rtl/cs_y_fifo_mem.sv
// DEPTH x Y_W sample storage: one synchronous write port, one asynchronous read port.
module cs_y_fifo_mem
    import cs_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  y_t               wdata,
    input  logic [PTR_W-1:0] raddr,
    output y_t               rdata
);

    y_t mem [DEPTH];

    // Storage is deliberately left unreset; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cs_y_buffer.sv
// Output FIFO behind the CS datapath: skips warm-up samples, buffers Y, counts overflow drops.
module cs_y_buffer
    import cs_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WARMUP = DEFAULT_WARMUP,
    parameter int OVF_W  = 16
) (
    input logic          clk,
    input logic          reset,
    cs_y_buffer_if.slave bus
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int WCNT_W = $clog2(WARMUP + 1);
    localparam logic [WCNT_W-1:0] WARM_TOP  = WCNT_W'(WARMUP);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

    logic [WCNT_W-1:0] wcnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_nxt;
    logic              full_q;
    logic              empty_q;
    logic [OVF_W-1:0]  ovf_q;
    y_t                rd_data;

    logic capture;
    logic push;
    logic pop;
    logic drop;

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign capture = bus.run && (wcnt == WARM_TOP);
    assign pop     = !empty_q && bus.dout_ready;
    assign push    = capture && (!full_q || pop);
    assign drop    = capture && full_q && !pop;

    always_comb begin
        level_nxt = level_q;
        case ({push, pop})
            2'b10:   level_nxt = level_q + LVL_W'(1);
            2'b01:   level_nxt = level_q - LVL_W'(1);
            default: level_nxt = level_q;
        endcase
    end

    // Any run=0 cycle breaks the CS window, so the warm-up count restarts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= '0;
        end else begin
            if (!bus.run) begin
                wcnt <= '0;
            end else if (wcnt != WARM_TOP) begin
                wcnt <= wcnt + WCNT_W'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            level_q <= level_nxt;
            full_q  <= (level_nxt == LVL_FULL);
            empty_q <= (level_nxt == '0);

            if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    cs_y_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.Y),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Unreset storage must not leak onto dout while the FIFO is empty.
    assign bus.dout       = empty_q ? '0 : rd_data;
    assign bus.dout_valid = !empty_q;
    assign bus.level      = level_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_cs_y_buffer.sv
// Directed and randomized-backpressure bench for cs_y_buffer with a queue scoreboard.
module tb_cs_y_buffer;
    import cs_pkg::*;

    localparam int DEPTH  = 16;
    localparam int WARMUP = DEFAULT_WARMUP;
    localparam int OVF_W  = 16;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] sb [$];
    int         m_wcnt  = 0;
    int         m_level = 0;
    int         m_ovf   = 0;
    int         exp_val;

    cs_y_buffer_if #(.DEPTH(DEPTH), .OVF_W(OVF_W)) bus ();

    cs_y_buffer #(
        .DEPTH  (DEPTH),
        .WARMUP (WARMUP),
        .OVF_W  (OVF_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; drives one cycle and checks state after the next posedge.
    task automatic apply_stimulus(input logic r, input logic [9:0] y, input logic rdy);
        bit m_pop, m_cap, m_push, m_drop;
        bus.run        = r;
        bus.Y          = y;
        bus.dout_ready = rdy;
        #1;
        if (m_level != 0) begin
            check_output("head_dout", {22'd0, bus.dout}, {22'd0, sb[0]});
        end
        m_pop  = (m_level != 0) && rdy;
        m_cap  = r && (m_wcnt == WARMUP);
        m_push = m_cap && ((m_level < DEPTH) || m_pop);
        m_drop = m_cap && (m_level == DEPTH) && !m_pop;
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back(y);
        if (m_drop && m_ovf < (1 << OVF_W) - 1) m_ovf++;
        m_level = m_level + int'(m_push) - int'(m_pop);
        if (!r) m_wcnt = 0;
        else if (m_wcnt < WARMUP) m_wcnt++;
        @(posedge clk);
        @(negedge clk);
        check_output("level", 32'(bus.level), m_level);
        check_output("full", 32'(bus.full), 32'(m_level == DEPTH));
        check_output("empty", 32'(bus.empty), 32'(m_level == 0));
        check_output("dout_valid", 32'(bus.dout_valid), 32'(m_level != 0));
        check_output("ovf_cnt", 32'(bus.ovf_cnt), m_ovf);
    endtask

    initial begin
        bus.run        = 1'b0;
        bus.Y          = '0;
        bus.dout_ready = 1'b0;
        reset          = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_valid", 32'(bus.dout_valid), 0);
        check_output("rst_empty", 32'(bus.empty), 1);
        check_output("rst_full", 32'(bus.full), 0);
        check_output("rst_level", 32'(bus.level), 0);
        check_output("rst_ovf", 32'(bus.ovf_cnt), 0);
        check_output("rst_dout", 32'(bus.dout), 0);
        reset = 1'b1;

        $display("[TB] warm-up");
        for (int i = 1; i <= 30; i++) begin
            apply_stimulus(1'b1, 10'(i), 1'b1);
            if (i == 9) check_output("warm_no_valid", 32'(bus.dout_valid), 0);
            if (i >= 10) check_output("warm_dout", 32'(bus.dout), i);
        end

        $display("[TB] run gap");
        apply_stimulus(1'b0, 10'h0, 1'b1);
        for (int k = 1; k <= 5; k++) apply_stimulus(1'b1, 10'(32'h0F0 + k), 1'b1);
        apply_stimulus(1'b0, 10'h0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            apply_stimulus(1'b1, 10'(32'h100 + k), 1'b1);
            if (k == 9) check_output("gap_empty", 32'(bus.empty), 1);
        end
        check_output("gap_first", 32'(bus.dout), 32'h10A);

        $display("[TB] fill and overflow");
        apply_stimulus(1'b0, 10'h0, 1'b1);
        for (int k = 1; k <= WARMUP; k++) apply_stimulus(1'b1, 10'(32'h1F0 + k), 1'b0);
        for (int j = 0; j < 20; j++) apply_stimulus(1'b1, 10'(32'h200 + j), 1'b0);
        check_output("fill_full", 32'(bus.full), 1);
        check_output("fill_level", 32'(bus.level), 16);
        check_output("fill_ovf", 32'(bus.ovf_cnt), 4);
        for (int j = 0; j < 16; j++) begin
            check_output("drain_order", 32'(bus.dout), 32'h200 + j);
            apply_stimulus(1'b0, 10'h0, 1'b1);
        end
        check_output("drain_empty", 32'(bus.empty), 1);

        $display("[TB] full with simultaneous pop");
        for (int k = 1; k <= WARMUP; k++) apply_stimulus(1'b1, 10'h0, 1'b0);
        for (int j = 0; j < 16; j++) apply_stimulus(1'b1, 10'(32'h300 + j), 1'b0);
        check_output("fp_full_before", 32'(bus.full), 1);
        apply_stimulus(1'b1, 10'h3FF, 1'b1);
        check_output("fp_level", 32'(bus.level), 16);
        check_output("fp_ovf", 32'(bus.ovf_cnt), 4);
        check_output("fp_head", 32'(bus.dout), 32'h301);
        for (int j = 0; j < 16; j++) begin
            exp_val = (j == 15) ? 32'h3FF : 32'h301 + j;
            check_output("fp_order", 32'(bus.dout), exp_val);
            apply_stimulus(1'b0, 10'h0, 1'b1);
        end

        $display("[TB] random backpressure");
        for (int k = 1; k <= WARMUP; k++) apply_stimulus(1'b1, 10'h0, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            apply_stimulus(1'b1, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
        end
        $display("[TB] drops counted so far: %0d", m_ovf);
        for (int n = 0; n < DEPTH; n++) apply_stimulus(1'b0, 10'h0, 1'b1);
        check_output("bp_drained", 32'(bus.empty), 1);

        $display("[TB] reset mid-stream");
        for (int k = 1; k <= WARMUP; k++) apply_stimulus(1'b1, 10'h0, 1'b0);
        for (int j = 0; j < 7; j++) apply_stimulus(1'b1, 10'(32'h040 + j), 1'b0);
        check_output("mid_level7", 32'(bus.level), 7);
        reset = 1'b0;
        #1;
        check_output("mid_rst_valid", 32'(bus.dout_valid), 0);
        check_output("mid_rst_level", 32'(bus.level), 0);
        check_output("mid_rst_ovf", 32'(bus.ovf_cnt), 0);
        check_output("mid_rst_empty", 32'(bus.empty), 1);
        sb.delete();
        m_level = 0;
        m_wcnt  = 0;
        m_ovf   = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            apply_stimulus(1'b1, 10'(32'h050 + i), 1'b1);
            if (i == 9) check_output("post_rst_warm", 32'(bus.dout_valid), 0);
        end
        check_output("post_rst_first", 32'(bus.dout), 32'h05A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cs_y_buffer.md
# cs_y_buffer

Output buffer placed directly downstream of the CS datapath. It discards the CS warm-up outputs after each (re)start, captures one 10-bit Y sample per clock once the 9-sample window is full, and holds the samples in a small FIFO. Samples leave through a valid/ready port, so a slower consumer (output writer, bus bridge) can stall without losing data until the FIFO overflows. Overflow is counted, not hidden.

## Interface
- DEPTH, 16: FIFO entries; power of two, 4..64.
- WARMUP, 9: run cycles discarded after start before the first capture.
- OVF_W, 16: width of the overflow counter.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- run  in  1  high in every cycle in which CS receives a valid X (stream active).
- Y  in  10  CS output, sampled on posedge clk.
- dout  out  10  FIFO head sample.
- dout_valid  out  1  dout holds a valid sample.
- dout_ready  in  1  consumer accepts dout this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- ovf_cnt  out  OVF_W  samples dropped because the FIFO was full; saturates.

## Operation
- Warm-up counter wcnt, range 0..WARMUP:
  - increments in each cycle with run=1 and wcnt<WARMUP;
  - clears to 0 in any cycle with run=0, because the window is broken and CS must refill it;
  - holds at WARMUP.
- Capture request: run=1 && wcnt==WARMUP. The first captured sample is therefore run cycle WARMUP+1 (the 10th with default).
- Push: capture request && (!full || pop). Drop: capture request && full && !pop.
- Pop: dout_valid && dout_ready.
- Push and pop in the same cycle:
  - level unchanged;
  - when full, the push is accepted and no drop occurs;
  - when empty, no push/pop conflict can arise, because dout_valid=0.
- Drop: ovf_cnt increments by 1, saturating at 2^OVF_W-1. FIFO contents are untouched; the newest sample is lost.
- dout_valid = !empty. dout = entry at the read pointer. Order is strictly FIFO.
- dout holds stable while dout_valid=1 && dout_ready=0.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. level is tracked as a separate counter.
- Reset (asynchronous, any time, including mid-stream):
  - wcnt=0, pointers=0, level=0, ovf_cnt=0;
  - outputs dout_valid=0, empty=1, full=0, dout=0;
  - storage contents are not reset.

## Timing
- Capture-to-output latency is 1 cycle: a sample pushed at edge k appears on dout with dout_valid=1 after edge k. There is no combinational fall-through from Y to dout.
- level, full, empty and ovf_cnt are registered and update on the same edge as the push, pop or drop that changes them.
- dout_ready→pop is sampled at the edge; no combinational path exists from dout_ready to any output.
- After reset release with run=1 continuously, the first push occurs at the (WARMUP+1)th posedge with run=1.
- Throughput is one push and one pop per cycle.

## Structure
- Shared package cs_pkg holds:
  - X_W=8, Y_W=10;
  - the default WARMUP=9 constant, shared with CS and the benches.
- One sub-module, cs_y_fifo_mem: a DEPTH×Y_W register array with one write port and an asynchronous read port.
- Pointer, level, warm-up and overflow logic stay in cs_y_buffer.

## Test plan
- Warm-up: reset, then run=1 with Y=0x001,0x002,… each cycle and dout_ready=1 → first dout is 0x00A, dout_valid rises after the 10th edge, and outputs are consecutive after that.
- Run gap: run=0 for one cycle after 5 run cycles → wcnt clears, 9 further run cycles are discarded, and the sample on the 10th is captured.
- Fill and overflow: dout_ready=0, 20 captures with DEPTH=16 → full=1, level=16, ovf_cnt=4; draining then yields the first 16 samples in order.
- Full with simultaneous pop: full, capture with dout_ready=1 → level stays 16, ovf_cnt unchanged, the new sample lands at the tail.
- Backpressure: toggle dout_ready randomly for 2000 samples → output sequence equals input sequence minus counted drops; dout stable while stalled.
- Reset mid-stream: assert reset with level=7 → dout_valid=0, level=0 and ovf_cnt=0 immediately (asynchronously); after release, warm-up restarts from 0.
